// File: rtl/filter_ctrl.sv
// filter_ctrl: aligns XVGA sync/blank with the Sobel filter pipeline,
// masks the frame border and selects the display mode per frame.
module filter_ctrl #(
    parameter int SOBEL_DLY = 5,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [23:0] rgb_in,
    input  logic [7:0]  rgb_gray,
    input  logic [23:0] rgb_edge,
    input  logic [23:0] rgb_cartoon,
    input  logic [1:0]  mode_req,
    input  logic        mode_req_valid,
    output logic [23:0] pixel_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic [1:0]  mode_cur,
    output logic        mode_ack,
    output logic [7:0]  frame_cnt
);

    typedef enum logic {
        WAIT_FRAME,
        RUN
    } state_t;

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

    state_t state;
    state_t state_next;

    logic [10:0] hc_pipe   [SOBEL_DLY];
    logic [9:0]  vc_pipe   [SOBEL_DLY];
    logic [23:0] rgb_pipe  [SOBEL_DLY];
    logic [7:0]  gray_pipe [SOBEL_DLY];
    logic [SOBEL_DLY-1:0] hs_pipe;
    logic [SOBEL_DLY-1:0] vs_pipe;
    logic [SOBEL_DLY-1:0] bl_pipe;

    logic [10:0] hcount_d;
    logic [9:0]  vcount_d;
    logic [23:0] rgb_in_d;
    logic [7:0]  rgb_gray_d;
    logic        hsync_d;
    logic        vsync_d;
    logic        blank_d;

    logic        vsync_prev;
    logic        frame_start;
    logic        pend;
    logic [1:0]  pend_mode;
    logic        border;
    logic [23:0] pixel_sel;

    assign hcount_d   = hc_pipe[SOBEL_DLY-1];
    assign vcount_d   = vc_pipe[SOBEL_DLY-1];
    assign rgb_in_d   = rgb_pipe[SOBEL_DLY-1];
    assign rgb_gray_d = gray_pipe[SOBEL_DLY-1];
    assign hsync_d    = hs_pipe[SOBEL_DLY-1];
    assign vsync_d    = vs_pipe[SOBEL_DLY-1];
    assign blank_d    = bl_pipe[SOBEL_DLY-1];

    // Frame boundary: falling edge of the undelayed vsync.
    assign frame_start = vsync_prev & ~vsync;

    // Delay line that brings coordinates, syncs and source pixels in step
    // with the filter outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
            bl_pipe <= '1;
            for (int i = 0; i < SOBEL_DLY; i++) begin
                hc_pipe[i]   <= '0;
                vc_pipe[i]   <= '0;
                rgb_pipe[i]  <= '0;
                gray_pipe[i] <= '0;
            end
        end else begin
            hc_pipe[0]   <= hcount;
            vc_pipe[0]   <= vcount;
            rgb_pipe[0]  <= rgb_in;
            gray_pipe[0] <= rgb_gray;
            hs_pipe[0]   <= hsync;
            vs_pipe[0]   <= vsync;
            bl_pipe[0]   <= blank;
            for (int i = 1; i < SOBEL_DLY; i++) begin
                hc_pipe[i]   <= hc_pipe[i-1];
                vc_pipe[i]   <= vc_pipe[i-1];
                rgb_pipe[i]  <= rgb_pipe[i-1];
                gray_pipe[i] <= gray_pipe[i-1];
                hs_pipe[i]   <= hs_pipe[i-1];
                vs_pipe[i]   <= vs_pipe[i-1];
                bl_pipe[i]   <= bl_pipe[i-1];
            end
        end
    end

    // State register plus vsync history for boundary detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_FRAME;
            vsync_prev <= 1'b1;
        end else begin
            state      <= state_next;
            vsync_prev <= vsync;
        end
    end

    // Leave WAIT_FRAME at the first boundary; RUN is only left by reset.
    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_FRAME: if (frame_start) state_next = RUN;
            RUN:        state_next = RUN;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    // Pending mode capture and frame-boundary application.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_mode <= 2'd0;
            mode_cur  <= 2'd0;
            mode_ack  <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            mode_ack <= 1'b0;
            if (frame_start) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (pend) begin
                    mode_cur <= pend_mode;
                    mode_ack <= 1'b1;
                end
            end
            // A request on the boundary cycle survives for the next boundary.
            if (mode_req_valid) begin
                pend      <= 1'b1;
                pend_mode <= mode_req;
            end else if (frame_start) begin
                pend <= 1'b0;
            end
        end
    end

    // Border masking and display mode selection.
    always_comb begin
        border = (hcount_d == 11'd0) || (hcount_d == H_LAST) ||
                 (vcount_d == 10'd0) || (vcount_d == V_LAST);
        pixel_sel = 24'd0;
        if (state == RUN && !blank_d) begin
            unique case (mode_cur)
                2'd0: pixel_sel = rgb_in_d;
                2'd1: pixel_sel = {rgb_gray_d, rgb_gray_d, rgb_gray_d};
                2'd2: pixel_sel = border ? 24'hFFFFFF : rgb_edge;
                2'd3: pixel_sel = border ? rgb_in_d : rgb_cartoon;
                default: pixel_sel = 24'd0;
            endcase
        end
    end

    // Output register after selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out <= 24'd0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            blank_out <= 1'b1;
        end else begin
            pixel_out <= pixel_sel;
            hsync_out <= hsync_d;
            vsync_out <= vsync_d;
            blank_out <= blank_d;
        end
    end

endmodule

// File: tb/tb_filter_ctrl.sv
// tb_filter_ctrl: directed sequence with random pixel data, checked
// against a sample-history reference model of filter_ctrl.
module tb_filter_ctrl;

    localparam int DLY = 5;
    localparam int HA  = 8;
    localparam int VA  = 6;
    localparam int HT  = 12;
    localparam int VT  = 10;

    typedef struct packed {
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
        logic [7:0]  gray;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync, vsync, blank;
    logic [23:0] rgb_in, rgb_edge, rgb_cartoon;
    logic [7:0]  rgb_gray;
    logic [1:0]  mode_req;
    logic        mode_req_valid;
    logic [23:0] pixel_out;
    logic        hsync_out, vsync_out, blank_out;
    logic [1:0]  mode_cur;
    logic        mode_ack;
    logic [7:0]  frame_cnt;

    filter_ctrl #(
        .SOBEL_DLY(DLY),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hcount        (hcount),
        .vcount        (vcount),
        .hsync         (hsync),
        .vsync         (vsync),
        .blank         (blank),
        .rgb_in        (rgb_in),
        .rgb_gray      (rgb_gray),
        .rgb_edge      (rgb_edge),
        .rgb_cartoon   (rgb_cartoon),
        .mode_req      (mode_req),
        .mode_req_valid(mode_req_valid),
        .pixel_out     (pixel_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .blank_out     (blank_out),
        .mode_cur      (mode_cur),
        .mode_ack      (mode_ack),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc;
    int gh, gv;
    int ack_cnt;
    logic gray_fix = 1'b0;

    // Reference model state: input history plus display/mode status.
    smp_t       ring [8];
    logic       prev_vs;
    logic       m_run;
    logic [1:0] m_mode, m_pmode;
    logic       m_pend, m_ack;
    logic [7:0] m_fc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic reset_model();
        cyc     = 0;
        for (int i = 0; i < 8; i++)
            ring[i] = '{11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 24'd0, 8'd0};
        prev_vs = 1'b1;
        m_run   = 1'b0;
        m_mode  = 2'd0;
        m_pmode = 2'd0;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
        m_fc    = 8'd0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_pixel", pixel_out, 0);
        chk("rst_hsync", hsync_out, 1);
        chk("rst_vsync", vsync_out, 1);
        chk("rst_blank", blank_out, 1);
        chk("rst_mode_cur", mode_cur, 0);
        chk("rst_mode_ack", mode_ack, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
    endtask

    function automatic logic is_border(input smp_t d);
        return d.hc == 11'(0) || d.hc == 11'(HA - 1) ||
               d.vc == 10'(0) || d.vc == 10'(VA - 1);
    endfunction

    // One pixel clock: drive the raster position, then check all outputs.
    task automatic step(input logic rv, input logic [1:0] rq);
        smp_t s, d;
        logic bnd;
        logic [23:0] exp_pix;
        hcount         = 11'(gh);
        vcount         = 10'(gv);
        hsync          = !(gh >= 9 && gh <= 10);
        vsync          = !(gv >= 7 && gv <= 8);
        blank          = (gh >= HA) || (gv >= VA);
        rgb_in         = 24'($urandom);
        rgb_gray       = gray_fix ? 8'h5A : 8'($urandom);
        rgb_edge       = 24'($urandom);
        rgb_cartoon    = 24'($urandom);
        mode_req_valid = rv;
        mode_req       = rq;
        @(posedge clk);
        #1;
        cyc++;
        s = '{hcount, vcount, hsync, vsync, blank, rgb_in, rgb_gray};
        ring[cyc % 8] = s;
        d = ring[(cyc + 8 - DLY) % 8];
        if (!m_run || d.bl) exp_pix = 24'd0;
        else begin
            case (m_mode)
                2'd0: exp_pix = d.rgb;
                2'd1: exp_pix = {3{d.gray}};
                2'd2: exp_pix = is_border(d) ? 24'hFFFFFF : rgb_edge;
                default: exp_pix = is_border(d) ? d.rgb : rgb_cartoon;
            endcase
        end
        bnd     = prev_vs && !s.vs;
        prev_vs = s.vs;
        m_ack   = 1'b0;
        if (bnd) begin
            m_run = 1'b1;
            m_fc  = m_fc + 8'd1;
            if (m_pend) begin
                m_mode = m_pmode;
                m_ack  = 1'b1;
                m_pend = 1'b0;
            end
        end
        if (rv) begin
            m_pend  = 1'b1;
            m_pmode = rq;
        end
        chk("pixel_out", pixel_out, exp_pix);
        chk("hsync_out", hsync_out, d.hs);
        chk("vsync_out", vsync_out, d.vs);
        chk("blank_out", blank_out, d.bl);
        chk("mode_cur", mode_cur, m_mode);
        chk("mode_ack", mode_ack, m_ack);
        chk("frame_cnt", frame_cnt, m_fc);
        if (mode_ack === 1'b1) ack_cnt++;
        gh++;
        if (gh == HT) begin
            gh = 0;
            gv = (gv + 1) % VT;
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0);
    endtask

    // Step until the next pixel to be driven is (th, tv).
    task automatic go_to(input int th, input int tv);
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (gh == th && gv == tv) break;
            step(1'b0, 2'd0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        hcount         = '0;
        vcount         = '0;
        hsync          = 1'b1;
        vsync          = 1'b1;
        blank          = 1'b1;
        rgb_in         = '0;
        rgb_gray       = '0;
        rgb_edge       = '0;
        rgb_cartoon    = '0;
        mode_req       = '0;
        mode_req_valid = 1'b0;
        ack_cnt        = 0;
        reset_model();
        @(posedge clk);
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        gh = 0;
        gv = 3;

        // Waiting for the first boundary, then two frames of PASS.
        go_to(0, 7);
        chk("pre_boundary_frame_cnt", frame_cnt, 0);
        step(1'b0, 2'd0);
        chk("first_frame_cnt", frame_cnt, 1);
        run_n(HT * VT);
        chk("second_frame_cnt", frame_cnt, 2);

        // EDGE requested mid-frame.
        go_to(3, 2);
        step(1'b1, 2'd2);
        go_to(0, 7);
        chk("edge_mode_held", mode_cur, 0);
        ack_cnt = 0;
        step(1'b0, 2'd0);
        chk("edge_ack", mode_ack, 1);
        chk("edge_mode_cur", mode_cur, 2);
        go_to(0, 2);
        run_n(DLY + 1);
        chk("edge_border_px", pixel_out, 24'hFFFFFF);
        run_n(HT * VT);
        chk("edge_ack_once", ack_cnt, 1);

        // Two requests in one frame: the latest wins, one ack.
        go_to(2, 1);
        step(1'b1, 2'd1);
        go_to(5, 4);
        step(1'b1, 2'd3);
        ack_cnt = 0;
        go_to(0, 7);
        run_n(20);
        chk("latest_wins_acks", ack_cnt, 1);
        chk("latest_wins_mode", mode_cur, 3);

        // Request exactly on the boundary cycle.
        go_to(0, 7);
        step(1'b1, 2'd1);
        chk("bnd_req_no_ack", mode_ack, 0);
        chk("bnd_req_mode_kept", mode_cur, 3);
        go_to(0, 7);
        step(1'b0, 2'd0);
        chk("bnd_req_next_ack", mode_ack, 1);
        chk("bnd_req_next_mode", mode_cur, 1);

        // GRAY with a constant gray level.
        gray_fix = 1'b1;
        go_to(3, 2);
        run_n(DLY + 1);
        chk("gray_active", pixel_out, 24'h5A5A5A);
        go_to(9, 2);
        run_n(DLY + 1);
        chk("gray_blanked", pixel_out, 0);
        gray_fix = 1'b0;

        // Random requests and data over several frames.
        for (int i = 0; i < 4 * HT * VT; i++)
            step($urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)));

        // CARTOON, then asynchronous reset mid-frame.
        go_to(0, 0);
        step(1'b1, 2'd3);
        go_to(0, 7);
        step(1'b0, 2'd0);
        chk("cartoon_mode", mode_cur, 3);
        go_to(4, 3);
        run_n(2);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        go_to(0, 7);
        step(1'b0, 2'd0);
        chk("post_rst_frame_cnt", frame_cnt, 1);
        chk("post_rst_mode", mode_cur, 0);
        run_n(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filter_ctrl.md
# filter_ctrl

Sequencer and output selector for the Sobel edge / cartoon filter path. Sits between the XVGA timing source and the display driver. Delays sync and blanking so they line up with the filter latency, and masks the frame border where the 3x3 window is invalid. Selects one of four display modes, and applies mode changes only at frame boundaries so a frame is never mixed.

## Interface
Parameters:
- SOBEL_DLY, 5 — filter pipeline latency in cycles from `rgb_gray`/`rgb_in` to `rgb_edge`/`rgb_cartoon`; must be ≥1
- H_ACTIVE, 640 — active pixels per line
- V_ACTIVE, 480 — active lines per frame

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hcount  in  11  horizontal pixel index of the current input pixel
- vcount  in  10  vertical line index of the current input pixel
- hsync  in  1  active-low horizontal sync
- vsync  in  1  active-low vertical sync
- blank  in  1  high outside the active area
- rgb_in  in  24  source pixel, undelayed
- rgb_gray  in  8  grayscale of `rgb_in`, undelayed
- rgb_edge  in  24  filter edge output, already SOBEL_DLY behind the inputs
- rgb_cartoon  in  24  filter cartoon output, already SOBEL_DLY behind the inputs
- mode_req  in  2  requested mode: 0 PASS, 1 GRAY, 2 EDGE, 3 CARTOON
- mode_req_valid  in  1  single-cycle strobe that captures `mode_req`
- pixel_out  out  24  selected display pixel
- hsync_out, vsync_out, blank_out  out  1 each  syncs aligned with `pixel_out`
- mode_cur  out  2  mode currently being displayed
- mode_ack  out  1  one-cycle pulse when a pending mode is applied
- frame_cnt  out  8  frames started since reset; wraps 255→0

## Operation
Alignment pipeline:
- `hcount`, `vcount`, `hsync`, `vsync`, `blank`, `rgb_in` and `rgb_gray` each pass through a SOBEL_DLY-stage shift register (the "_d" values).
- This puts them in step with `rgb_edge` and `rgb_cartoon`.

Output stage: one register after the selection.
- If `blank_d` is high: `pixel_out` = 0.
- PASS: `rgb_in_d`.
- GRAY: {`rgb_gray_d`, `rgb_gray_d`, `rgb_gray_d`}.
- EDGE: `rgb_edge`. Border pixels output 24'hFFFFFF.
- CARTOON: `rgb_cartoon`. Border pixels output `rgb_in_d`.
- A border pixel is one where `hcount_d`==0, `hcount_d`==H_ACTIVE-1, `vcount_d`==0 or `vcount_d`==V_ACTIVE-1.

Mode handling:
- `mode_req_valid` loads `mode_req` into the pending register and sets the pend flag.
- A later request before the boundary overwrites the pending value; the latest request wins.
- The frame boundary is the falling edge of the input `vsync`, detected against a registered copy.
- At the boundary with pend set: `mode_cur` ← pending, pend clears, `mode_ack` pulses.
- A request in the same cycle as the boundary is not applied at that boundary. It becomes pending for the next one.
- A request equal to `mode_cur` still pends and still acks.

FSM:
- WAIT_FRAME: entered at reset.
  - `pixel_out` forced to 0.
  - Syncs still propagate.
  - Moves to RUN at the first boundary.
- RUN: normal selection.
  - Each boundary increments `frame_cnt` and applies any pending mode.
- There is no exit from RUN except reset.

## Timing
- Latency from inputs to `hsync_out`/`vsync_out`/`blank_out`/`pixel_out` is SOBEL_DLY+1 cycles.
- A mode applied at boundary cycle T is used for pixels entering the input at T+1 and later.
  - Pixels already in the pipeline keep being selected by `mode_cur`; they are vsync-region pixels and are blanked.
- `mode_ack` and the `mode_cur` update are registered, visible at T+1.
- `frame_cnt` also updates at T+1.
- Reset values:
  - `pixel_out`=0
  - `hsync_out`=1, `vsync_out`=1, `blank_out`=1
  - `mode_cur`=0, `mode_ack`=0, `frame_cnt`=0
  - pend=0, state=WAIT_FRAME
  - all delay stages: syncs=1, blank=1, data=0
- Reset asserted mid-frame clears everything immediately (asynchronous). After release, the block waits for a fresh boundary.

## Test plan
- Reset, then run two frames with a ramp on `rgb_in`. Expect `pixel_out`=0 until the first `vsync` falling edge. Afterwards `pixel_out` equals `rgb_in` delayed 6 cycles (SOBEL_DLY=5), and `frame_cnt` reads 1 then 2.
- In RUN, request `mode_req`=2 mid-frame. Expect `mode_cur` to stay 0 until the boundary, then `mode_ack` to pulse once and `mode_cur`=2. Border pixel (0,10) outputs FFFFFF; interior pixels equal `rgb_edge`.
- Request 1 then 3 within the same frame. Expect one ack at the boundary and `mode_cur`=3.
- Assert `mode_req_valid` exactly on the boundary cycle. Expect no ack at that boundary and an ack at the next one.
- GRAY mode with `rgb_gray`=8'h5A. Expect `pixel_out`=24'h5A5A5A in the active area and 0 while blanked.
- Assert `rst` mid-frame while in CARTOON. Expect all outputs to reach their reset values in the same cycle, and `mode_cur`=0 once the next frame starts.
